uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 157 +++++++++++++++
 tb/tb_uart_rx_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with oversampled start/data/stop sampling feeding a small
// first-word-fall-through byte FIFO with frame-error and overrun pulses.
module uart_rx_buffer #(
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] state_out
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_frame_err;
    logic          r_overrun;

    logic w_stop_sample;
    logic w_good;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign data_out  = empty ? 8'h00 : r_mem[r_rd];
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign state_out = r_state;

    assign w_stop_sample = tick && (r_state == ST_STOP) && (r_cnt == FULL_M1);
    assign w_good        = w_stop_sample && r_rx_s;
    assign w_pop         = rd_en && !empty;
    // A pop in the stop-sample cycle frees the slot the new byte needs.
    assign w_push        = w_good && (!full || w_pop);
    assign w_drop        = w_good && full && !w_pop;

    // Synchronizer resets to the idle line level so release never fakes a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= 8'h00;
        end else if (tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_state <= r_rx_s ? ST_IDLE : ST_DATA;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_cnt   <= '0;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == FULL_M1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample && !r_rx_s;
            r_overrun   <= w_drop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= r_shift;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: serial frames driven bit by bit, received
// bytes tracked by a scoreboard queue, flags and FSM states logged by a monitor.
module tb_uart_rx_buffer;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       rx;
    logic       rd_en;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;
    logic [1:0] state_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;

    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [1:0] st_q[$];
    logic [1:0] prev_st = 2'd0;

    uart_rx_buffer #(
        .OVERSAMPLE(OS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .rx       (rx),
        .rd_en    (rd_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .frame_err(frame_err),
        .overrun  (overrun),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: flag pulse cycles and every FSM state change.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (state_out !== prev_st) begin
            st_q.push_back(state_out);
            prev_st = state_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    // Stop sample lands 11 clocks into the stop bit (2 sync + start/data alignment).
    task automatic send(input logic [7:0] b, input logic stop, input logic pop_at_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        rx = stop;
        repeat (10) @(posedge clk);
        #1;
        if (pop_at_stop) begin
            chk("pop_at_stop_head", {24'h0, data_out}, {24'h0, q[0]});
            void'(q.pop_front());
            rd_en = 1'b1;
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        if (!stop) exp_fe++;
        else if (q.size() < DEPTH) q.push_back(b);
        else exp_ov++;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag);
        @(negedge clk);
        chk(tag, {24'h0, data_out}, {24'h0, q[0]});
        chk({tag, "_nonempty"}, {31'h0, empty}, 32'h0);
        void'(q.pop_front());
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    function automatic logic [31:0] seq_from(input int idx);
        logic [31:0] s = 32'h0;
        for (int i = idx; i < st_q.size(); i++) s = (s << 4) | {30'h0, st_q[i]};
        return s;
    endfunction

    initial begin
        int idx;
        reset = 1'b0;
        tick  = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        #1;
        chk("rst_state", {30'h0, state_out}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_data", {24'h0, data_out}, 32'h0);
        chk("rst_flags", {30'h0, frame_err, overrun}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0x55 clean frame
        idx = st_q.size();
        send(8'h55, 1'b1, 1'b0);
        chk("seq_55", seq_from(idx), 32'h1230);
        chk("empty_55", {31'h0, empty}, 32'h0);
        chk("fe_55", fe_cnt, exp_fe);
        chk("ov_55", ov_cnt, exp_ov);
        pop_chk("data_55");
        chk("empty_after_pop", {31'h0, empty}, 32'h1);

        // start-bit glitch
        idx = st_q.size();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("seq_glitch", seq_from(idx), 32'h10);
        chk("empty_glitch", {31'h0, empty}, 32'h1);
        chk("fe_glitch", fe_cnt, 0);

        // bad stop bit
        send(8'hA3, 1'b0, 1'b0);
        chk("fe_a3", fe_cnt, exp_fe);
        chk("empty_a3", {31'h0, empty}, 32'h1);

        // fill and overrun
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
        chk("full_4", {31'h0, full}, 32'h1);
        chk("ov_before", ov_cnt, 0);
        send(8'h05, 1'b1, 1'b0);
        chk("ov_5th", ov_cnt, exp_ov);
        chk("full_5th", {31'h0, full}, 32'h1);
        for (int i = 0; i < 4; i++) pop_chk("drain_01_04");
        chk("empty_drain", {31'h0, empty}, 32'h1);
        chk("full_drain", {31'h0, full}, 32'h0);

        // pop coinciding with stop sample while full
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, 1'b0);
        chk("full_10_13", {31'h0, full}, 32'h1);
        send(8'h7E, 1'b1, 1'b1);
        chk("ov_7e", ov_cnt, exp_ov);
        chk("full_7e", {31'h0, full}, 32'h1);
        for (int i = 0; i < 3; i++) pop_chk("drain_11_13");
        @(negedge clk);
        chk("head_7e", {24'h0, data_out}, 32'h7E);

        // reset during data bit 4 of 0xC9 with a byte still buffered
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC9 >> i));
        rx = 1'(8'hC9 >> 4);
        repeat (8) @(posedge clk);
        #1;
        chk("state_mid_c9", {30'h0, state_out}, 32'h2);
        reset = 1'b0;
        #1;
        q.delete();
        chk("mr_state", {30'h0, state_out}, 32'h0);
        chk("mr_empty", {31'h0, empty}, 32'h1);
        chk("mr_full", {31'h0, full}, 32'h0);
        chk("mr_data", {24'h0, data_out}, 32'h0);
        chk("mr_flags", {30'h0, frame_err, overrun}, 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(8'h3C, 1'b1, 1'b0);
        chk("fe_total", fe_cnt, exp_fe);
        chk("ov_total", ov_cnt, exp_ov);
        pop_chk("data_3c");
        chk("empty_end", {31'h0, empty}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
